trace_dispatcher: RTL

Initiator side of the reorder_logic_top trace interface. Accepts whole instructions (1..MAX_UOPS micro-ops, each with a target queue selector) over a valid/ready handshake, assigns a sequential ID, and serializes the micro-ops onto trace_push/trace_sel/trace_break/trace_id_push while honouring the reorder full flag. It also drains the committed-ID queue, checks in-order commit against the IDs it issued, and limits in-flight IDs to DEPTH.

---
 rtl/reorder_logic_pkg.sv | 25 ++
 rtl/trace_dispatcher.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reorder_logic_pkg.sv
// Shared definitions for the reorder trace interface: width derivations, FSM encoding,
// and the default breakpoint polarity.
package reorder_logic_pkg;

  typedef enum logic [0:0] {
    StateIdle,
    StateIssue
  } state_e;

  localparam logic BreakpointDefault = 1'b1;

  // Widths never collapse to zero, so degenerate parameters still elaborate.
  function automatic int unsigned sel_width(input int unsigned num_queues);
    return (num_queues > 1) ? $clog2(num_queues) : 1;
  endfunction

  function automatic int unsigned id_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_uops);
    return $clog2(max_uops + 1);
  endfunction

endpackage

// File: rtl/trace_dispatcher.sv
// Initiator for the reorder trace interface: accepts instructions, serializes their micro-ops,
// tags them with sequential IDs and checks that IDs come back in order.
module trace_dispatcher
  import reorder_logic_pkg::*;
#(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_UOPS   = 4,
  parameter logic        BREAKPOINT = BreakpointDefault,
  localparam int unsigned SEL_WIDTH = sel_width(NUM_QUEUES),
  localparam int unsigned ID_WIDTH  = id_width(DEPTH),
  localparam int unsigned CNT_WIDTH = cnt_width(MAX_UOPS),
  localparam int unsigned OCC_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  input  logic [CNT_WIDTH-1:0]          instr_uops_i,
  input  logic [MAX_UOPS*SEL_WIDTH-1:0] instr_sel_i,
  output logic [ID_WIDTH-1:0]           accept_id_o,
  input  logic                          full_i,
  output logic                          trace_push_o,
  output logic [SEL_WIDTH-1:0]          trace_sel_o,
  output logic                          trace_break_o,
  output logic                          trace_id_push_o,
  output logic [ID_WIDTH-1:0]           trace_id_value_o,
  input  logic                          commit_id_valid_i,
  input  logic [ID_WIDTH-1:0]           commit_id_value_i,
  output logic                          commit_id_pull_o,
  output logic [OCC_WIDTH-1:0]          outstanding_o,
  output logic                          error_o
);

  state_e                        state_q, state_d;
  logic [ID_WIDTH-1:0]           next_id_q, next_id_d;
  logic [ID_WIDTH-1:0]           exp_commit_q, exp_commit_d;
  logic [OCC_WIDTH-1:0]          outstanding_q, outstanding_d;
  logic                          error_q, error_d;
  logic [CNT_WIDTH-1:0]          idx_q, idx_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic [MAX_UOPS*SEL_WIDTH-1:0] sel_q, sel_d;

  logic                 last_uop;
  logic                 pull;
  logic [CNT_WIDTH-1:0] cnt_clamped;

  always_comb begin
    if (instr_uops_i == '0) begin
      cnt_clamped = CNT_WIDTH'(1);
    end else if (instr_uops_i > CNT_WIDTH'(MAX_UOPS)) begin
      cnt_clamped = CNT_WIDTH'(MAX_UOPS);
    end else begin
      cnt_clamped = instr_uops_i;
    end
  end

  assign last_uop = (idx_q == cnt_q - CNT_WIDTH'(1));

  // Instruction side FSM; every output is forced low while reset is held.
  always_comb begin
    state_d          = state_q;
    next_id_d        = next_id_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    sel_d            = sel_q;
    instr_ready_o    = 1'b0;
    accept_id_o      = '0;
    trace_push_o     = 1'b0;
    trace_sel_o      = '0;
    trace_break_o    = 1'b0;
    trace_id_push_o  = 1'b0;
    trace_id_value_o = '0;

    if (!rst_i) begin
      unique case (state_q)
        StateIdle: begin
          instr_ready_o = (outstanding_q < OCC_WIDTH'(DEPTH));
          accept_id_o   = next_id_q;
          if (instr_valid_i && instr_ready_o) begin
            sel_d   = instr_sel_i;
            cnt_d   = cnt_clamped;
            idx_d   = '0;
            state_d = StateIssue;
          end
        end
        StateIssue: begin
          trace_push_o     = ~full_i;
          trace_break_o    = last_uop ? BREAKPOINT : ~BREAKPOINT;
          trace_id_push_o  = trace_push_o & last_uop;
          trace_id_value_o = next_id_q;
          for (int k = 0; k < int'(MAX_UOPS); k++) begin
            if (idx_q == CNT_WIDTH'(k)) begin
              trace_sel_o = sel_q[k*SEL_WIDTH +: SEL_WIDTH];
            end
          end
          if (trace_push_o) begin
            if (last_uop) begin
              idx_d     = '0;
              next_id_d = next_id_q + ID_WIDTH'(1);
              state_d   = StateIdle;
            end else begin
              idx_d = idx_q + CNT_WIDTH'(1);
            end
          end
        end
        default: state_d = StateIdle;
      endcase
    end
  end

  // Commit checker: drain every offered ID and compare against the issue order.
  assign pull             = commit_id_valid_i & ~rst_i;
  assign commit_id_pull_o = pull;

  always_comb begin
    exp_commit_d  = exp_commit_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;
    if (pull) begin
      exp_commit_d = exp_commit_q + ID_WIDTH'(1);
      if ((commit_id_value_i != exp_commit_q) || (outstanding_q == '0)) begin
        error_d = 1'b1;
      end
    end
    unique case ({trace_id_push_o, pull})
      2'b10:   outstanding_d = outstanding_q + OCC_WIDTH'(1);
      2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - OCC_WIDTH'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  assign outstanding_o = outstanding_q;
  assign error_o       = error_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StateIdle;
      next_id_q     <= '0;
      exp_commit_q  <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      sel_q         <= '0;
    end else begin
      state_q       <= state_d;
      next_id_q     <= next_id_d;
      exp_commit_q  <= exp_commit_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
    end
  end

endmodule
